// File: rtl/reducer_pkg.sv
// Shared constants and arithmetic helpers for the pipelined row reducer.
package reducer_pkg;

  // Mode encoding carried by DW_PW_sel alongside each beat.
  localparam logic MODE_DW = 1'b0;
  localparam logic MODE_PW = 1'b1;

  // Default geometry of the PE array column interface.
  localparam int ROW_NUM_DEF = 32;
  localparam int DATA_W_DEF  = 16;
  localparam int GROUP_DEF   = 3;

  // Width of the common carrier used by sat_add; wide enough for any
  // exact group sum of DATA_W lanes that this block is configured with.
  localparam int WIDE_W = 64;

  typedef struct packed {
    logic              ovf;  // sum does not fit in data_w signed bits
    logic [WIDE_W-1:0] val;  // clamped (sat_en) or raw sum; low data_w bits are the result
  } sat_res_t;

  // Reduce an exact wide sum to a data_w-bit two's complement result.
  // With sat_en the value is clamped to the signed range; otherwise the
  // caller keeps the low data_w bits, which wraps modulo 2^data_w.
  function automatic sat_res_t sat_add(input logic signed [WIDE_W-1:0] sum,
                                       input int                       data_w,
                                       input logic                     sat_en);
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;
    sat_res_t                 r;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    r.ovf = (sum > max_v) || (sum < min_v);
    r.val = sum;
    if (sat_en && (sum > max_v)) begin
      r.val = max_v;
    end else if (sat_en && (sum < min_v)) begin
      r.val = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/reducer_group_add.sv
// Combinational adder: one partial sum plus GROUP product lanes, summed
// exactly in a widened signed accumulator, then clamped or wrapped.
module reducer_group_add
  import reducer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GROUP  = GROUP_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [DATA_W-1:0]       ipsum_i,
  input  logic [GROUP*DATA_W-1:0] prod_i,
  output logic [DATA_W-1:0]       sum_o,
  output logic                    ovf_o
);

  // GROUP+1 operands of DATA_W bits never exceed this width.
  localparam int SUM_W = DATA_W + $clog2(GROUP + 1);

  logic signed [SUM_W-1:0] acc;
  sat_res_t                res;
  logic                    unused_hi;

  // Exact sum of the sign-extended partial sum and all products.
  always_comb begin
    acc = SUM_W'(signed'(ipsum_i));
    for (int j = 0; j < GROUP; j++) begin
      acc = acc + SUM_W'(signed'(prod_i[j*DATA_W +: DATA_W]));
    end
  end

  // Narrow the exact sum back to the lane width.
  always_comb begin
    res = sat_add(WIDE_W'(acc), DATA_W, SAT_EN);
  end

  assign sum_o     = res.val[DATA_W-1:0];
  assign ovf_o     = res.ovf;
  assign unused_hi = ^res.val[WIDE_W-1:DATA_W];

endmodule

// File: rtl/reducer_pipe.sv
// Two-stage pipelined row reducer between the PE array column outputs and
// the opsum buffer. S1 registers the input beat and its mode; S2 registers
// the reduced lanes, the lane-valid mask and feeds the sticky overflow flag.
module reducer_pipe
  import reducer_pkg::*;
#(
  parameter int ROW_NUM = ROW_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GROUP   = GROUP_DEF,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      DW_PW_sel,
  input  logic [ROW_NUM*DATA_W-1:0] array2reducer,
  input  logic [ROW_NUM*DATA_W-1:0] ipsum2reducer,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROW_NUM*DATA_W-1:0] reducer2opsum,
  output logic [ROW_NUM-1:0]        out_mask,
  output logic                      sat_flag,
  input  logic                      sat_clr
);

  localparam int LW = ROW_NUM * DATA_W;
  // Number of complete groups in DW mode; leftover rows produce zeros.
  localparam int NG = ROW_NUM / GROUP;

  // Handshake: a stage accepts a beat when it is empty or when its current
  // beat leaves on the same edge; a beat moves on an edge where the sender's
  // valid and the receiver's ready are both 1. Data and valid of a stage
  // whose beat is not leaving stay unchanged.
  logic s1_ready;
  logic s2_ready;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_mode_q,  s1_mode_d;
  logic [LW-1:0]   s1_prod_q,  s1_prod_d;
  logic [LW-1:0]   s1_ipsum_q, s1_ipsum_d;

  logic            s2_valid_q, s2_valid_d;
  logic [LW-1:0]   s2_data_q,  s2_data_d;
  logic [ROW_NUM-1:0] s2_mask_q, s2_mask_d;

  logic            sat_q, sat_d;
  logic            sat_set;

  logic [LW-1:0]      pw_sum;
  logic [ROW_NUM-1:0] pw_ovf;
  logic [DATA_W-1:0]  dw_sum [NG];
  logic [NG-1:0]      dw_ovf;

  logic [LW-1:0]      res_data;
  logic [ROW_NUM-1:0] res_mask;
  logic               res_ovf;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  // Per-row adders used in PW mode.
  for (genvar k = 0; k < ROW_NUM; k++) begin : g_pw
    reducer_group_add #(
      .DATA_W(DATA_W),
      .GROUP (1),
      .SAT_EN(SAT_EN)
    ) u_add (
      .ipsum_i(s1_ipsum_q[k*DATA_W +: DATA_W]),
      .prod_i (s1_prod_q[k*DATA_W +: DATA_W]),
      .sum_o  (pw_sum[k*DATA_W +: DATA_W]),
      .ovf_o  (pw_ovf[k])
    );
  end

  // Group adders used in DW mode; group g lands on lane g*GROUP.
  for (genvar g = 0; g < NG; g++) begin : g_dw
    reducer_group_add #(
      .DATA_W(DATA_W),
      .GROUP (GROUP),
      .SAT_EN(SAT_EN)
    ) u_add (
      .ipsum_i(s1_ipsum_q[g*GROUP*DATA_W +: DATA_W]),
      .prod_i (s1_prod_q[g*GROUP*DATA_W +: GROUP*DATA_W]),
      .sum_o  (dw_sum[g]),
      .ovf_o  (dw_ovf[g])
    );
  end

  // Select the reduced lanes, mask and overflow for the beat held in S1.
  always_comb begin
    res_data = '0;
    res_mask = '0;
    res_ovf  = 1'b0;
    if (s1_mode_q == MODE_PW) begin
      res_data = pw_sum;
      res_mask = '1;
      res_ovf  = |pw_ovf;
    end else begin
      for (int g = 0; g < NG; g++) begin
        res_data[g*GROUP*DATA_W +: DATA_W] = dw_sum[g];
        res_mask[g*GROUP]                  = 1'b1;
        res_ovf                            = res_ovf | dw_ovf[g];
      end
    end
  end

  // Next-state for both pipeline stages and the sticky flag.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_prod_d  = s1_prod_q;
    s1_ipsum_d = s1_ipsum_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_mask_d  = s2_mask_q;
    sat_d      = sat_q;

    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d  = DW_PW_sel;
        s1_prod_d  = array2reducer;
        s1_ipsum_d = ipsum2reducer;
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = res_data;
        s2_mask_d = res_mask;
      end
    end

    // A new overflow on the S2 load edge beats a simultaneous clear.
    sat_set = s2_ready && s1_valid_q && res_ovf;
    if (sat_clr) begin
      sat_d = 1'b0;
    end
    if (sat_set) begin
      sat_d = 1'b1;
    end
  end

  // Pipeline registers; reset discards any beats in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_DW;
      s1_prod_q  <= '0;
      s1_ipsum_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mask_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_prod_q  <= s1_prod_d;
      s1_ipsum_q <= s1_ipsum_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_mask_q  <= s2_mask_d;
      sat_q      <= sat_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign reducer2opsum = s2_data_q;
  assign out_mask      = s2_mask_q;
  assign sat_flag      = sat_q;

endmodule

// File: tb/tb_reducer_pipe.sv
// Directed bench for reducer_pipe: a saturating and a wrapping instance see
// identical stimulus; a scoreboard checks every output beat in order.
module tb_reducer_pipe;
  import reducer_pkg::*;

  localparam int ROW_NUM = 32;
  localparam int DATA_W  = 16;
  localparam int GROUP   = 3;
  localparam int LW      = ROW_NUM * DATA_W;
  localparam int EW      = 2 * LW + ROW_NUM;
  localparam logic [ROW_NUM-1:0] MASK_PW = 32'hFFFF_FFFF;
  localparam logic [ROW_NUM-1:0] MASK_DW = 32'h0924_9249;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          DW_PW_sel;
  logic [LW-1:0] array2reducer;
  logic [LW-1:0] ipsum2reducer;
  logic          out_ready;
  logic          sat_clr;

  logic               s_in_ready, s_out_valid, s_flag;
  logic [LW-1:0]      s_data;
  logic [ROW_NUM-1:0] s_mask;
  logic               w_in_ready, w_out_valid, w_flag;
  logic [LW-1:0]      w_data;
  logic [ROW_NUM-1:0] w_mask;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_t_q[$];

  reducer_pipe #(.ROW_NUM(ROW_NUM), .DATA_W(DATA_W), .GROUP(GROUP), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .DW_PW_sel(DW_PW_sel),
    .array2reducer(array2reducer), .ipsum2reducer(ipsum2reducer), .out_valid(s_out_valid),
    .out_ready(out_ready), .reducer2opsum(s_data), .out_mask(s_mask), .sat_flag(s_flag),
    .sat_clr(sat_clr)
  );

  reducer_pipe #(.ROW_NUM(ROW_NUM), .DATA_W(DATA_W), .GROUP(GROUP), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .DW_PW_sel(DW_PW_sel),
    .array2reducer(array2reducer), .ipsum2reducer(ipsum2reducer), .out_valid(w_out_valid),
    .out_ready(out_ready), .reducer2opsum(w_data), .out_mask(w_mask), .sat_flag(w_flag),
    .sat_clr(sat_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checkers ----------------
  task automatic chk_v(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic [ROW_NUM-1:0] obs, input logic [ROW_NUM-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus tables ----------------
  // lane k = base + step*k
  function automatic logic [LW-1:0] fill(input int base, input int step);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < ROW_NUM; k++) v[k*DATA_W +: DATA_W] = 16'(base + step * k);
    return v;
  endfunction

  // products 1,2,3 repeating across each group of three rows
  function automatic logic [LW-1:0] dw_prod();
    logic [LW-1:0] v;
    for (int k = 0; k < ROW_NUM; k++) v[k*DATA_W +: DATA_W] = 16'((k % 3) + 1);
    return v;
  endfunction

  // 10 on group leaders, 5 elsewhere (non-leader ipsum is ignored in DW)
  function automatic logic [LW-1:0] dw_ipsum();
    logic [LW-1:0] v;
    for (int k = 0; k < ROW_NUM; k++) v[k*DATA_W +: DATA_W] = (k % 3 == 0) ? 16'd10 : 16'd5;
    return v;
  endfunction

  // DW result for the table above: 10+1+2+3 = 16 on lanes 0,3,..,27
  function automatic logic [LW-1:0] exp_dw();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < 30; k += 3) v[k*DATA_W +: DATA_W] = 16'd16;
    return v;
  endfunction

  // PW result for the same data: 11,7,8 repeating
  function automatic logic [LW-1:0] exp_pw_mix();
    logic [LW-1:0] v;
    for (int k = 0; k < ROW_NUM; k++)
      v[k*DATA_W +: DATA_W] = (k % 3 == 0) ? 16'd11 : ((k % 3 == 1) ? 16'd7 : 16'd8);
    return v;
  endfunction

  function automatic logic [LW-1:0] sat_prod();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < 3; k++) v[k*DATA_W +: DATA_W] = 16'h7000;
    for (int k = 3; k < 6; k++) v[k*DATA_W +: DATA_W] = 16'h8000;
    return v;
  endfunction

  function automatic logic [LW-1:0] sat_ipsum();
    logic [LW-1:0] v;
    v = '0;
    v[0*DATA_W +: DATA_W] = 16'h7000;
    v[3*DATA_W +: DATA_W] = 16'h8000;
    return v;
  endfunction

  // 4*0x7000 clamps to 7FFF, 4*(-0x8000) clamps to 8000
  function automatic logic [LW-1:0] sat_exp_s();
    logic [LW-1:0] v;
    v = '0;
    v[0*DATA_W +: DATA_W] = 16'h7FFF;
    v[3*DATA_W +: DATA_W] = 16'h8000;
    return v;
  endfunction

  // 0x1C000 wraps to C000, -0x20000 wraps to 0000
  function automatic logic [LW-1:0] sat_exp_w();
    logic [LW-1:0] v;
    v = '0;
    v[0*DATA_W +: DATA_W] = 16'hC000;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the
  // accepting rising edge, with acc = number of that rising edge.
  task automatic push(input logic mode, input logic [LW-1:0] prod, input logic [LW-1:0] ipsum,
                      output int acc);
    int budget;
    in_valid      = 1'b1;
    DW_PW_sel     = mode;
    array2reducer = prod;
    ipsum2reducer = ipsum;
    #2;
    budget = 0;
    while (!s_in_ready && budget < 50) begin
      @(negedge clk);
      #2;
      budget++;
    end
    chk_b("push_in_ready", s_in_ready, 1'b1);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    DW_PW_sel     = 1'($urandom_range(0, 1));
    array2reducer = {16{32'($urandom)}};
    ipsum2reducer = {16{32'($urandom)}};
  endtask

  task automatic expect_beat(input logic [LW-1:0] e_sat, input logic [LW-1:0] e_wrap,
                             input logic [ROW_NUM-1:0] mask, input int t);
    exp_q.push_back({e_sat, e_wrap, mask});
    exp_t_q.push_back(t);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_i(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    int            t;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && s_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_beat observed=out_valid=1 expected=no pending beat");
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          chk_v("beat_sat_data", s_data, e[EW-1 -: LW]);
          chk_v("beat_wrap_data", w_data, e[ROW_NUM +: LW]);
          chk_m("beat_mask", s_mask, e[ROW_NUM-1:0]);
          chk_m("beat_wrap_mask", w_mask, e[ROW_NUM-1:0]);
          chk_b("beat_wrap_valid", w_out_valid, 1'b1);
          if (t >= 0) chk_i("beat_latency", cyc + 1, t);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int prev;
    logic [EW-1:0] f;
    logic mode;

    rst = 1'b1; in_valid = 1'b0; DW_PW_sel = MODE_DW;
    array2reducer = '0; ipsum2reducer = '0; out_ready = 1'b0; sat_clr = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk_b("rst_out_valid", s_out_valid, 1'b0);
    chk_b("rst_sat_flag", s_flag, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_b("post_rst_in_ready", s_in_ready, 1'b1);
    chk_b("post_rst_in_ready_w", w_in_ready, 1'b1);
    chk_v("post_rst_data", s_data, '0);
    chk_m("post_rst_mask", s_mask, '0);
    chk_b("post_rst_flag_w", w_flag, 1'b0);

    // reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    push(MODE_DW, sat_prod(), sat_ipsum(), acc);
    push(MODE_PW, fill(0, 1), fill(100, 0), acc);
    idle();
    #1;
    chk_b("inflight_out_valid", s_out_valid, 1'b1);
    chk_b("inflight_in_ready", s_in_ready, 1'b0);
    chk_b("inflight_sat_flag", s_flag, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_b("async_rst_out_valid", s_out_valid, 1'b0);
    chk_b("async_rst_out_valid_w", w_out_valid, 1'b0);
    chk_b("async_rst_sat_flag", s_flag, 1'b0);
    chk_b("async_rst_sat_flag_w", w_flag, 1'b0);
    chk_m("async_rst_mask", s_mask, '0);
    chk_v("async_rst_data", s_data, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk_b("after_rst_in_ready", s_in_ready, 1'b1);
    chk_b("after_rst_no_output", s_out_valid, 1'b0);

    // PW streaming, one beat per cycle
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      push(MODE_PW, fill(0, 1), fill(100 + 1000 * j, 0), acc);
      expect_beat(fill(100 + 1000 * j, 1), fill(100 + 1000 * j, 1), MASK_PW, acc + 2);
    end
    idle();
    drain("pw_drain");

    // DW with default grouping
    push(MODE_DW, dw_prod(), dw_ipsum(), acc);
    expect_beat(exp_dw(), exp_dw(), MASK_DW, acc + 2);
    idle();
    drain("dw_drain");
    #1;
    chk_b("no_ovf_flag", s_flag, 1'b0);
    chk_b("no_ovf_flag_w", w_flag, 1'b0);

    // saturation / wrap and the sticky flag
    @(negedge clk);
    push(MODE_DW, sat_prod(), sat_ipsum(), acc);
    expect_beat(sat_exp_s(), sat_exp_w(), MASK_DW, acc + 2);
    idle();
    drain("sat_drain");
    #1;
    chk_b("sat_flag_set", s_flag, 1'b1);
    chk_b("wrap_flag_set", w_flag, 1'b1);
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    #1;
    chk_b("sat_flag_clr", s_flag, 1'b0);
    chk_b("wrap_flag_clr", w_flag, 1'b0);

    // set and clear on the same edge: set wins
    @(negedge clk);
    push(MODE_DW, sat_prod(), sat_ipsum(), acc);
    idle();
    expect_beat(sat_exp_s(), sat_exp_w(), MASK_DW, acc + 2);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    #1;
    chk_b("set_beats_clr", s_flag, 1'b1);
    chk_b("set_beats_clr_w", w_flag, 1'b1);
    drain("sat2_drain");
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;

    // backpressure: five back-to-back beats, consumer stalls four cycles
    fork
      begin
        int a;
        for (int j = 0; j < 5; j++) begin
          push(MODE_PW, fill(j, 1), fill(50 * j, 0), a);
          expect_beat(fill(51 * j, 1), fill(51 * j, 1), MASK_PW, -1);
        end
        idle();
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!s_out_valid && n < 20) begin
          @(negedge clk);
          #1;
          n++;
        end
        chk_b("bp_first_valid", s_out_valid, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #1;
          f = exp_q[0];
          chk_b("bp_hold_valid", s_out_valid, 1'b1);
          chk_v("bp_hold_data", s_data, f[EW-1 -: LW]);
          chk_m("bp_hold_mask", s_mask, f[ROW_NUM-1:0]);
          chk_b("bp_in_ready_low", s_in_ready, 1'b0);
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // per-beat mode switch, no bubbles
    @(negedge clk);
    prev = 0;
    for (int j = 0; j < 6; j++) begin
      mode = (j % 2 == 0) ? MODE_PW : MODE_DW;
      push(mode, dw_prod(), dw_ipsum(), acc);
      if (mode == MODE_PW) expect_beat(exp_pw_mix(), exp_pw_mix(), MASK_PW, acc + 2);
      else                 expect_beat(exp_dw(), exp_dw(), MASK_DW, acc + 2);
      if (j > 0) chk_i("switch_accept_edge", acc, prev + 1);
      prev = acc;
    end
    idle();
    drain("switch_drain");
    repeat (3) @(negedge clk);
    #1;
    chk_b("final_idle", s_out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
